seq_detector: RTL and testbench

Serial pattern detector that consumes the single-bit stream produced by the lab's D flip-flop / shift-register stages. It samples `d` on each enabled clock, keeps a sliding history of the last `PAT_W` bits, and pulses `detect` whenever that history equals `PATTERN`. Overlapping matches count. A saturating counter records the number of matches since reset. It is the consumer stage directly downstream of the `dff` block, and it reuses `dff` as its input register.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_detector_if.sv | 13 +
 rtl/seq_detector_dff.sv | 14 +
 rtl/seq_detector.sv | 86 ++++++++
 tb/tb_seq_detector.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } fill_state_t;

  // Width needed to count valid bits from 0 up to pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Stream-in / detect-out bundle between a bit source and the pattern detector.
interface seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             d;
  logic             en;
  logic             detect;
  logic [CNT_W-1:0] count;
  logic             armed;

  modport master (output d, en, input detect, count, armed);
  modport slave  (input d, en, output detect, count, armed);
endinterface

// File: rtl/seq_detector_dff.sv
// Single-bit D flip-flop with asynchronous active-high reset; the detector's input register.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/seq_detector.sv
// Sliding-window serial pattern detector with a fill guard and saturating match counter.
//
//   state   | meaning
//   EMPTY   | no valid bit taken since reset
//   FILLING | 1..PAT_W-1 valid bits in hist
//   ARMED   | hist holds PAT_W valid bits; stays here until reset
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  seq_detector_if.slave bus
);

  localparam int             FW        = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX  = FW'(PAT_W);
  localparam logic [FW-1:0]  FILL_LAST = FW'(PAT_W - 1);

  logic             d_q, en_q;
  logic [PAT_W-1:0] hist_q, hist_d, next_hist;
  logic [FW-1:0]    fill_q, fill_d;
  fill_state_t      state_q, state_d;
  logic             detect_q, detect_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             armed_q, armed_d;
  logic             full_next;

  dff u_dff_d  (.clk(clk), .rst(rst), .d(bus.d),  .q(d_q));
  dff u_dff_en (.clk(clk), .rst(rst), .d(bus.en), .q(en_q));

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    count_d   = count_q;
    next_hist = {hist_q[PAT_W-2:0], d_q};
    // The incoming bit completes a full window only once PAT_W-1 valid bits precede it.
    full_next = (fill_q >= FILL_LAST) || (state_q == ARMED);
    detect_d  = en_q && full_next && (next_hist == PATTERN);

    if (en_q) begin
      hist_d = next_hist;
      unique case (state_q)
        EMPTY: begin
          state_d = FILLING;
          fill_d  = FW'(1);
        end
        FILLING: begin
          fill_d = fill_q + 1'b1;
          if (fill_q + 1'b1 == FILL_MAX) state_d = ARMED;
        end
        default: ;
      endcase
    end

    if (detect_d && (count_q != '1)) count_d = count_q + 1'b1;
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      state_q  <= EMPTY;
      detect_q <= 1'b0;
      count_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      detect_q <= detect_d;
      count_q  <= count_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.detect = detect_q;
  assign bus.count  = count_q;
  assign bus.armed  = armed_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: three configurations driven one scenario at a time.
module tb_seq_detector;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       det_s, arm_s;
  logic [7:0] cnt_s;

  always #5 clk = ~clk;

  seq_detector_if #(.CNT_W(8)) if0 ();
  seq_detector_if #(.CNT_W(8)) if1 ();
  seq_detector_if #(.CNT_W(2)) if2 ();

  seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_def (.clk(clk), .rst(rst), .bus(if0));
  seq_detector #(.PAT_W(4), .PATTERN(4'b0001), .CNT_W(8)) u_pre (.clk(clk), .rst(rst), .bus(if1));
  seq_detector #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if2));

  task automatic sample(input int u);
    case (u)
      0: begin det_s = if0.detect; arm_s = if0.armed; cnt_s = if0.count; end
      1: begin det_s = if1.detect; arm_s = if1.armed; cnt_s = if1.count; end
      default: begin det_s = if2.detect; arm_s = if2.armed; cnt_s = {6'd0, if2.count}; end
    endcase
  endtask

  task automatic step(input int u, input logic dv, input logic ev);
    @(negedge clk);
    case (u)
      0: begin if0.d = dv; if0.en = ev; end
      1: begin if1.d = dv; if1.en = ev; end
      default: begin if2.d = dv; if2.en = ev; end
    endcase
    @(posedge clk);
    #1;
    sample(u);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if0.d = 1'b0; if0.en = 1'b0;
    if1.d = 1'b0; if1.en = 1'b0;
    if2.d = 1'b0; if2.en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int u = 0; u < 3; u++) begin
      sample(u);
      n_checks++;
      if (det_s !== 1'b0 || arm_s !== 1'b0 || cnt_s !== 8'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: detect=%b armed=%b count=%0d, expected 0/0/0", u, det_s, arm_s, cnt_s);
      end
    end
  endtask

  task automatic test_single_match();
    bit         dv [0:5] = '{1, 0, 1, 1, 0, 0};
    bit         ev [0:5] = '{1, 1, 1, 1, 0, 0};
    bit         xd [0:5] = '{0, 0, 0, 0, 1, 0};
    bit         xa [0:5] = '{0, 0, 0, 0, 1, 1};
    logic [7:0] xc [0:5] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, dv[i], ev[i]);
      n_checks++;
      if (det_s !== xd[i] || arm_s !== xa[i] || cnt_s !== xc[i]) begin
        n_fail++;
        $display("FAIL single step %0d: detect=%b armed=%b count=%0d, expected %b/%b/%0d",
                 i, det_s, arm_s, cnt_s, xd[i], xa[i], xc[i]);
      end
    end
  endtask

  task automatic test_overlap();
    bit         dv [0:8] = '{1, 0, 1, 1, 0, 1, 1, 0, 0};
    bit         ev [0:8] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    bit         xd [0:8] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    logic [7:0] xc [0:8] = '{0, 0, 0, 0, 1, 1, 1, 2, 2};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, dv[i], ev[i]);
      n_checks++;
      if (det_s !== xd[i] || cnt_s !== xc[i]) begin
        n_fail++;
        $display("FAIL overlap step %0d: detect=%b count=%0d, expected %b/%0d", i, det_s, cnt_s, xd[i], xc[i]);
      end
    end
  endtask

  task automatic test_en_gaps();
    bit         dv [0:8] = '{1, 0, 1, 0, 1, 1, 1, 0, 0};
    bit         ev [0:8] = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    bit         xd [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [7:0] xc [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(0, dv[i], ev[i]);
      n_checks++;
      if (det_s !== xd[i] || cnt_s !== xc[i]) begin
        n_fail++;
        $display("FAIL en_gaps step %0d: detect=%b count=%0d, expected %b/%0d", i, det_s, cnt_s, xd[i], xc[i]);
      end
    end
  endtask

  task automatic test_prefill_guard();
    bit         dv [0:8] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         ev [0:8] = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
    bit         xd [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit         xa [0:8] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [7:0] xc [0:8] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, dv[i], ev[i]);
      n_checks++;
      if (det_s !== xd[i] || arm_s !== xa[i] || cnt_s !== xc[i]) begin
        n_fail++;
        $display("FAIL prefill step %0d: detect=%b armed=%b count=%0d, expected %b/%b/%0d",
                 i, det_s, arm_s, cnt_s, xd[i], xa[i], xc[i]);
      end
    end
  endtask

  task automatic test_saturation();
    bit         xd [0:10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] xc [0:10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(2, 1'b1, (i < 9) ? 1'b1 : 1'b0);
      n_checks++;
      if (det_s !== xd[i] || cnt_s !== xc[i]) begin
        n_fail++;
        $display("FAIL saturation step %0d: detect=%b count=%0d, expected %b/%0d", i, det_s, cnt_s, xd[i], xc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit dv [0:17] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    bit exp_det;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(0, dv[i], 1'b1);
      exp_det = (i == 4 || i == 7 || i == 10 || i == 13 || i == 16);
      n_checks++;
      if (det_s !== exp_det) begin
        n_fail++;
        $display("FAIL reset_mid stream step %0d: detect=%b expected %b", i, det_s, exp_det);
      end
    end
    n_checks++;
    if (cnt_s !== 8'd5) begin
      n_fail++;
      $display("FAIL reset_mid precount: count=%0d expected 5", cnt_s);
    end
    #1 rst = 1'b1;
    #1 sample(0);
    n_checks++;
    if (det_s !== 1'b0 || arm_s !== 1'b0 || cnt_s !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid async: detect=%b armed=%b count=%0d, expected 0/0/0", det_s, arm_s, cnt_s);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 0) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0);
      n_checks++;
      if (det_s !== 1'b0 || arm_s !== 1'b0 || cnt_s !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_mid after step %0d: detect=%b armed=%b count=%0d, expected 0/0/0",
                 i, det_s, arm_s, cnt_s);
      end
    end
  endtask

  initial begin
    if0.d = 1'b0; if0.en = 1'b0;
    if1.d = 1'b0; if1.en = 1'b0;
    if2.d = 1'b0; if2.en = 1'b0;
    test_reset();
    test_single_match();
    test_overlap();
    test_en_gaps();
    test_prefill_guard();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
